// File: rtl/madd_seq.sv
`default_nettype none
// ============================================================================
// Module   : madd_seq
// Brief    : Sequencer that streams queued operands into a multiply-add
//            datapath, runs it for a fixed time and captures the result.
// Revision : 1.0 - initial release
// ============================================================================
module madd_seq #(
    parameter int DEPTH      = 8,
    parameter int RUN_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     start,
    input  logic [4:0]               len,
    input  logic [1:0]               insn,
    input  logic [11:0]              madd_out,
    output logic                     madd_load,
    output logic                     madd_run,
    output logic [1:0]               madd_insn,
    output logic [3:0]               madd_index,
    output logic [3:0]               madd_data,
    output logic [11:0]              res,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy
);

    localparam int         c_aw       = $clog2(DEPTH);
    localparam int         c_lw       = c_aw + 1;
    localparam logic [7:0] c_run_last = 8'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state, w_state_nx;
    logic [7:0]      r_queue [DEPTH];
    logic [c_lw-1:0] r_ptr, w_ptr_nx;
    logic [c_lw-1:0] r_len, w_len_nx;
    logic [c_lw-1:0] w_eff_len;
    logic [7:0]      r_cnt, w_cnt_nx;
    logic [1:0]      r_insn, w_insn_nx;
    logic            w_load_nx, w_run_nx, w_valid_nx;
    logic [1:0]      w_minsn_nx;
    logic [7:0]      w_entry_nx;
    logic [11:0]     w_res_nx;

    // Queue has no reset; a same-edge write and read naturally yields the old entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_queue[wr_addr] <= wr_data;
        end
    end

    assign w_eff_len = (len >= 5'(DEPTH)) ? c_lw'(DEPTH) : len[c_lw-1:0];

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_len_nx   = r_len;
        w_cnt_nx   = r_cnt;
        w_insn_nx  = r_insn;
        w_load_nx  = 1'b0;
        w_run_nx   = 1'b0;
        w_minsn_nx = 2'd0;
        w_entry_nx = 8'd0;
        w_res_nx   = res;
        w_valid_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_insn_nx  = insn;
                    w_len_nx   = w_eff_len;
                    w_minsn_nx = insn;
                    if (w_eff_len != '0) begin
                        w_state_nx = S_LOAD;
                        w_load_nx  = 1'b1;
                        w_entry_nx = r_queue[0];
                        w_ptr_nx   = c_lw'(1);
                    end else begin
                        w_state_nx = S_RUN;
                        w_run_nx   = 1'b1;
                        w_ptr_nx   = '0;
                        w_cnt_nx   = c_run_last;
                    end
                end
            end
            S_LOAD: begin
                w_minsn_nx = r_insn;
                if (r_ptr == r_len) begin
                    w_state_nx = S_RUN;
                    w_run_nx   = 1'b1;
                    w_cnt_nx   = c_run_last;
                end else begin
                    w_load_nx  = 1'b1;
                    w_entry_nx = r_queue[r_ptr[c_aw-1:0]];
                    w_ptr_nx   = r_ptr + c_lw'(1);
                end
            end
            S_RUN: begin
                if (r_cnt == 8'd0) begin
                    w_state_nx = S_CAPTURE;
                end else begin
                    w_run_nx   = 1'b1;
                    w_minsn_nx = r_insn;
                    w_cnt_nx   = r_cnt - 8'd1;
                end
            end
            S_CAPTURE: begin
                w_state_nx = S_DONE;
                w_res_nx   = madd_out;
                w_valid_nx = 1'b1;
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_valid_nx = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Every output is a flop loaded with the value for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_len      <= '0;
            r_cnt      <= 8'd0;
            r_insn     <= 2'd0;
            madd_load  <= 1'b0;
            madd_run   <= 1'b0;
            madd_insn  <= 2'd0;
            madd_index <= 4'd0;
            madd_data  <= 4'd0;
            res        <= 12'd0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_len      <= w_len_nx;
            r_cnt      <= w_cnt_nx;
            r_insn     <= w_insn_nx;
            madd_load  <= w_load_nx;
            madd_run   <= w_run_nx;
            madd_insn  <= w_minsn_nx;
            madd_index <= w_entry_nx[7:4];
            madd_data  <= w_entry_nx[3:0];
            res        <= w_res_nx;
            res_valid  <= w_valid_nx;
            busy       <= (w_state_nx != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_madd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_madd_seq
// Brief    : Directed and randomized jobs against a cycle-count model of madd_seq.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_madd_seq;

    localparam int DEPTH      = 8;
    localparam int RUN_CYCLES = 16;
    localparam int AW         = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          start;
    logic [4:0]    len;
    logic [1:0]    insn;
    logic [11:0]   madd_out;
    logic          madd_load, madd_run;
    logic [1:0]    madd_insn;
    logic [3:0]    madd_index, madd_data;
    logic [11:0]   res;
    logic          res_valid, res_ready, busy;

    int            total = 0;
    int            bad   = 0;
    logic [7:0]    mdl_q [DEPTH];
    logic [11:0]   exp_res;

    madd_seq #(.DEPTH(DEPTH), .RUN_CYCLES(RUN_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .insn(insn), .madd_out(madd_out),
        .madd_load(madd_load), .madd_run(madd_run), .madd_insn(madd_insn),
        .madd_index(madd_index), .madd_data(madd_data), .res(res),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_load"},  32'(madd_load),  0);
        chk({tag, "_run"},   32'(madd_run),   0);
        chk({tag, "_insn"},  32'(madd_insn),  0);
        chk({tag, "_index"}, 32'(madd_index), 0);
        chk({tag, "_data"},  32'(madd_data),  0);
        chk({tag, "_valid"}, 32'(res_valid),  0);
        chk({tag, "_busy"},  32'(busy),       0);
        chk({tag, "_res"},   32'(res),        32'(exp_res));
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        step();
        wr_en   = 1'b0;
        mdl_q[a] = d;
    endtask

    // One job: cycle c counts from the start cycle; loads fill cycles 1..L,
    // run fills the next RUN_CYCLES, then one capture cycle, then DONE.
    task automatic run_job(input int ln, input logic [1:0] op, input int wait_n,
                           input logic [11:0] mo, input bit poke,
                           input int hit_addr, input logic [7:0] hit_data);
        int         l_eff, hs, first_v;
        bit         in_load, in_run, in_done;
        logic [7:0] ent;
        logic [7:0] snap [DEPTH];
        l_eff   = (ln > DEPTH) ? DEPTH : ln;
        hs      = l_eff + RUN_CYCLES + 2 + wait_n;
        snap    = mdl_q;
        first_v = -1;
        chk_quiet("pre");
        start = 1'b1;
        len   = 5'(ln);
        insn  = op;
        step();
        for (int c = 1; c <= hs; c++) begin
            in_load = (c <= l_eff);
            in_run  = (c > l_eff) && (c <= l_eff + RUN_CYCLES);
            in_done = (c >= l_eff + RUN_CYCLES + 2);
            ent     = in_load ? snap[c-1] : 8'h00;
            chk("load",  32'(madd_load),  32'(in_load));
            chk("run",   32'(madd_run),   32'(in_run));
            chk("minsn", 32'(madd_insn),  (in_load || in_run) ? 32'(op) : 0);
            chk("index", 32'(madd_index), 32'(ent[7:4]));
            chk("data",  32'(madd_data),  32'(ent[3:0]));
            chk("busy",  32'(busy),       1);
            chk("valid", 32'(res_valid),  32'(in_done));
            chk("exclusive", 32'(madd_load & madd_run), 0);
            if (in_done) chk("res", 32'(res), 32'(mo));
            if (res_valid === 1'b1 && first_v < 0) first_v = c;
            madd_out  = (c == l_eff + RUN_CYCLES + 1) ? mo : ~mo;
            res_ready = in_done ? (c == hs) : 1'($urandom);
            start     = poke && (c == 1 || c == l_eff + 2 || c == l_eff + RUN_CYCLES + 2 || c == hs);
            len       = 5'd3;
            insn      = 2'($urandom);
            wr_en     = (hit_addr >= 0) && (c == hit_addr);
            wr_addr   = AW'(hit_addr);
            wr_data   = hit_data;
            step();
            wr_en = 1'b0;
        end
        start     = 1'b0;
        res_ready = 1'b0;
        exp_res   = mo;
        if (hit_addr >= 0) mdl_q[hit_addr] = hit_data;
        chk("latency", 32'(first_v), 32'(l_eff + RUN_CYCLES + 2));
        chk_quiet("post");
        step();
        chk_quiet("post2");
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        len = '0; insn = '0; madd_out = '0; res_ready = 1'b0;
        exp_res = 12'h000;
        step();
        step();
        chk_quiet("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom));
        wr(0, 8'h12);
        wr(1, 8'h34);
        wr(2, 8'h56);
        run_job(3, 2'd2, 5, 12'hABC, 1'b0, -1, 8'h00);
        run_job(0, 2'd1, 0, 12'h123, 1'b0, -1, 8'h00);
        run_job(20, 2'd3, 1, 12'h5A5, 1'b0, -1, 8'h00);
        run_job(4, 2'd1, 2, 12'h3C3, 1'b1, -1, 8'h00);

        // Abort in the middle of RUN, then confirm nothing is reported.
        start = 1'b1; len = 5'd2; insn = 2'd1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("mid_run", 32'(madd_run), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_res = 12'h000;
        chk_quiet("abort");
        for (int i = 0; i < 25; i++) begin
            chk("abort_valid", 32'(res_valid), 0);
            step();
        end
        run_job(2, 2'd2, 0, 12'h777, 1'b0, -1, 8'h00);

        // Rewrite entry 1 on the same edge it is read: old value streams now.
        run_job(4, 2'd3, 0, 12'h0F0, 1'b0, 1, 8'hE7);
        run_job(2, 2'd0, 1, 12'h90F, 1'b0, -1, 8'h00);

        for (int j = 0; j < 6; j++) begin
            wr($urandom_range(0, DEPTH - 1), 8'($urandom));
            wr($urandom_range(0, DEPTH - 1), 8'($urandom));
            run_job($urandom_range(0, 20), 2'($urandom), $urandom_range(0, 4),
                    12'($urandom), 1'($urandom), -1, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/madd_seq.md
MADD_SEQ -- requirements
Module: madd_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of operand-queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter RUN_CYCLES, default 16: cycles madd_run is held per job (1..255).
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset; synchronous and active-low.
REQ-005 SHALL have port wr_en  in  1  write operand entry this cycle.
REQ-006 SHALL have port wr_addr  in  log2(DEPTH)  entry address.
REQ-007 SHALL have port wr_data  in  8  entry {index[3:0], data[3:0]}.
REQ-008 SHALL have port start  in  1  job request, sampled only in IDLE.
REQ-009 SHALL have port len  in  5  entries to stream for the job.
REQ-010 SHALL have port insn  in  2  opcode driven to datapath for the job.
REQ-011 SHALL have port madd_out  in  12  datapath result.
REQ-012 SHALL have ports madd_load (1), madd_run (1), madd_insn (2), madd_index (4), madd_data (4)  out  datapath control.
REQ-013 SHALL have port res  out  12  captured result.
REQ-014 SHALL have ports res_valid  out  1, res_ready  in  1  result handshake.
REQ-015 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, CAPTURE, DONE; all outputs registered.
REQ-017 Queue writes SHALL be accepted in every state; a write and a LOAD read of the same entry in one cycle SHALL return the old data.
REQ-018 IDLE: start=1 SHALL latch insn and eff_len = min(len, DEPTH), clear ptr; next state LOAD if eff_len>0, else RUN.
REQ-019 LOAD: madd_load=1 and {madd_index, madd_data}=queue[ptr] for exactly eff_len consecutive cycles, ptr incrementing 0..eff_len-1; then RUN.
REQ-020 RUN: madd_run=1 for exactly RUN_CYCLES consecutive cycles; madd_load=0; then CAPTURE.
REQ-021 madd_insn SHALL equal the latched insn throughout LOAD and RUN, 0 otherwise.
REQ-022 CAPTURE: one cycle, madd_run=0; res SHALL be loaded from madd_out; next DONE.
REQ-023 DONE: res_valid=1, res stable; on res_valid&&res_ready return to IDLE with res_valid=0 next cycle.
REQ-024 Latency start-to-res_valid SHALL be eff_len + RUN_CYCLES + 2 cycles.
REQ-025 start outside IDLE SHALL be ignored (no queueing); start in the same cycle as the DONE->IDLE handshake SHALL be ignored.
REQ-026 madd_load and madd_run SHALL never be high in the same cycle.
REQ-027 res SHALL hold its last captured value after DONE until the next CAPTURE.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, clear ptr, run counter, latched insn/len, res, and drive res_valid, busy, madd_load, madd_run, madd_insn, madd_index, madd_data to 0.
REQ-029 Reset mid-job SHALL abort it with no res_valid pulse; queue contents need not be reset.

Verification
REQ-030 Write entries 0..2 = 8'h12, 8'h34, 8'h56; start, len=3, insn=2 -> madd_load high 3 cycles with index/data 1/2, 3/4, 5/6, then madd_run high 16 cycles, madd_insn=2 throughout.
REQ-031 madd_out=12'hABC during CAPTURE, res_ready=0 for 5 cycles -> res=12'hABC, res_valid high until ready, total latency 21 cycles.
REQ-032 len=0 -> no madd_load pulse, RUN begins the cycle after start; len=20 -> exactly 8 load cycles.
REQ-033 start pulsed during LOAD, RUN and DONE -> ignored; busy stays 1 until handshake; exactly one result.
REQ-034 rst_n low for one cycle in the middle of RUN -> all outputs 0 next cycle, FSM IDLE, no res_valid; new job then completes normally.
REQ-035 wr_en to entry 1 during the LOAD cycle that reads entry 1 -> old value streamed; new value used on the next job.
